ctrl_decode_pipe: RTL and testbench
===================================

Name: ctrl_decode_pipe

Overview:
- Parametrised, registered successor to the combinational main control decoder.
- Decodes RV32I instructions, plus the optional RV32M extension, into the datapath control bundle. The result is held in an ID/EX output register with a valid/ready handshake.
- Adds load-use hazard stalling, branch/jump flush and illegal-opcode flagging.
- Sits between the IF/ID register and the execute stage of the 5-stage pipeline.

Parameters:
- ALU_OP_W, 6, width of the alu_op field; must be >= 5 when EN_M=1.
- EN_M, 0, 1 decodes the RV32M opcode space (funct7=0000001); 0 treats it as illegal.
- REG_AW, 5, register index width.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  kill the held and incoming instruction (taken branch or jump in EX).
- in_valid_i  in  1  instr_i is valid.
- in_ready_o  out  1  block accepts instr_i this cycle.
- instr_i  in  32  instruction from IF/ID.
- out_valid_o  out  1  control bundle valid.
- out_ready_i  in  1  execute stage consumes the bundle.
- alusrc1_o  out  1  1: PC, 0: rs1 data.
- alusrc2_o  out  1  1: immediate, 0: rs2 data.
- dmem_to_reg_o  out  2  00: memory, 01: ALU, 10: PC+4, 11: immediate.
- reg_write_o  out  1  register write enable.
- mem_read_o  out  1  data-memory read enable.
- mem_write_o  out  1  data-memory write enable.
- branch_o  out  1  conditional branch instruction.
- jump_o  out  1  JAL/JALR instruction.
- alu_op_o  out  ALU_OP_W  ALU operation code.
- rd_o  out  REG_AW  destination register index.
- illegal_o  out  1  unrecognised opcode or funct field.

Behaviour:
- Reset (reset_ni=0, asynchronous):
  - out_valid_o=0, illegal_o=0, every control output 0, rd_o=0.
  - Load-hazard tracker cleared.
  - Release takes effect on the next rising edge.
- Decode is combinational from instr_i. Results are registered on accept, where accept = in_valid_i & in_ready_o. Latency is one cycle from accept to out_valid_o.
- Field mapping:
  - LUI, AUIPC, JAL, JALR, BXX, LXX, SXX, IXX and RXX map as in the existing control table.
  - AUIPC dmem_to_reg=01.
  - R/I types: funct3 gives codes 0..7. SRA/SRAI=8, SUB=9, pass=15.
  - BEQ/BNE=9; BLT/BGE=2; BLTU/BGEU=3.
  - EN_M=1 and RXX with funct7=0000001: alu_op = 16 + funct3 (MUL..REMU).
  - Any other opcode, or funct7 outside {0000000, 0100000 (SUB/SRA only)}, or an M op with EN_M=0: illegal=1 and all write/enable controls 0.
- Output register:
  - Loads on accept.
  - Holds its value while out_valid_o=1 and out_ready_i=0.
  - Clears out_valid_o when consumed with no accept in the same cycle.
- in_ready_o = (~out_valid_o | out_ready_i) & ~hazard & ~flush_i.
- Load-use hazard:
  - When a bundle with mem_read=1 and rd≠0 is consumed, the tracker records rd and is armed for exactly one cycle.
  - hazard=1 when the tracker is armed and instr_i rs1 (used by every type except LUI, AUIPC and JAL) or rs2 (used by R, S and B types) equals the recorded rd.
  - Result: one bubble, then accept.
- Flush:
  - Next edge: out_valid_o=0 and tracker cleared.
  - No accept occurs in the flush cycle.
  - Flush has priority over accept, hold and hazard.
- Simultaneous consume and accept: the new bundle replaces the old one with no bubble.
- rd is x0: reg_write is forced 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams;
  - ALU op constants (ADD=0 … AND=7, SRA=8, SUB=9, PASS=15, MUL=16 … REMU=23);
  - the dmem_to_reg enum;
  - the ctrl_bundle_t struct.
- Sub-module ctrl_decode_comb: pure combinational decode, instr -> ctrl_bundle_t plus illegal flag.
- The top level adds the output register, handshake, hazard tracker and flush logic.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with out_ready_i=1.
  - Next cycle: out_valid_o=1, alu_op=0, reg_write=1, dmem_to_reg=01, rd=3.
- LW x5,0(x1) consumed, followed by ADD x6,x5,x2.
  - in_ready_o=0 for exactly one cycle, then the ADD is accepted.
  - ADD x6,x1,x2 in the same position causes no stall.
- out_ready_i=0 for 3 cycles with SUB held.
  - Outputs stable (alu_op=9).
  - in_ready_o=0 throughout.
  - Consumption and a new accept in the same cycle produce no bubble.
- flush_i with a bundle held and in_valid_i=1.
  - Next cycle: out_valid_o=0.
  - The incoming instruction is not accepted.
- EN_M=1: MUL x1,x2,x3 (0x023100B3) gives alu_op=16.
  - EN_M=0: the same instruction gives illegal=1 and reg_write=0.
- Opcode 0x7F gives illegal=1 with all enables 0.
  - Asserting reset_ni=0 mid-hold clears out_valid_o immediately.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the registered control decoder: RV32 opcodes,
// funct7 classes, ALU operation codes, write-back select and the bundle type.
package ctrl_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BXX   = 7'b1100011;
  localparam logic [6:0] OP_LXX   = 7'b0000011;
  localparam logic [6:0] OP_SXX   = 7'b0100011;
  localparam logic [6:0] OP_IXX   = 7'b0010011;
  localparam logic [6:0] OP_RXX   = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SLL    = 5'd1;
  localparam logic [4:0] ALU_SLT    = 5'd2;
  localparam logic [4:0] ALU_SLTU   = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SRL    = 5'd5;
  localparam logic [4:0] ALU_OR     = 5'd6;
  localparam logic [4:0] ALU_AND    = 5'd7;
  localparam logic [4:0] ALU_SRA    = 5'd8;
  localparam logic [4:0] ALU_SUB    = 5'd9;
  localparam logic [4:0] ALU_PASS   = 5'd15;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_t;

  typedef struct packed {
    logic       alusrc1;
    logic       alusrc2;
    wb_sel_t    dmem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [4:0] alu_op;
    logic [4:0] rd;
  } ctrl_bundle_t;

  // Base integer ops: funct3 selects the operation directly
  function automatic logic [4:0] alu_from_funct3(input logic [2:0] funct3);
    logic [4:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Multiply/divide ops: funct3 selects MUL..REMU
  function automatic logic [4:0] muldiv_from_funct3(input logic [2:0] funct3);
    logic [4:0] op;
    op = ALU_MUL;
    case (funct3)
      3'b000: op = ALU_MUL;
      3'b001: op = ALU_MULH;
      3'b010: op = ALU_MULHSU;
      3'b011: op = ALU_MULHU;
      3'b100: op = ALU_DIV;
      3'b101: op = ALU_DIVU;
      3'b110: op = ALU_REM;
      3'b111: op = ALU_REMU;
      default: op = ALU_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational RV32I(+M) control decode: instruction word to control
// bundle, illegal flag, and the source-register usage needed for hazards.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic         uses_rs1,
  output logic         uses_rs2,
  output logic [4:0]   rs1,
  output logic [4:0]   rs2
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Source-register usage by instruction format
  always_comb begin
    uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    uses_rs2 = (opcode == OP_RXX) || (opcode == OP_SXX) || (opcode == OP_BXX);
  end

  // Opcode/funct decode; illegal encodings collapse to an all-zero bundle
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl.alusrc2     = 1'b1;
        ctrl.dmem_to_reg = WB_IMM;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_op      = ALU_PASS;
        ctrl.rd          = rd;
      end
      OP_AUIPC: begin
        ctrl.alusrc1     = 1'b1;
        ctrl.alusrc2     = 1'b1;
        ctrl.dmem_to_reg = WB_ALU;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.rd          = rd;
      end
      OP_JAL: begin
        ctrl.alusrc1     = 1'b1;
        ctrl.alusrc2     = 1'b1;
        ctrl.dmem_to_reg = WB_PC4;
        ctrl.reg_write   = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.rd          = rd;
      end
      OP_JALR: begin
        ctrl.alusrc2     = 1'b1;
        ctrl.dmem_to_reg = WB_PC4;
        ctrl.reg_write   = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.rd          = rd;
      end
      OP_BXX: begin
        ctrl.branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: ctrl.alu_op = ALU_SUB;
          3'b100, 3'b101: ctrl.alu_op = ALU_SLT;
          3'b110, 3'b111: ctrl.alu_op = ALU_SLTU;
          default:        illegal     = 1'b1;
        endcase
      end
      OP_LXX: begin
        ctrl.alusrc2     = 1'b1;
        ctrl.dmem_to_reg = WB_MEM;
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.rd          = rd;
      end
      OP_SXX: begin
        ctrl.alusrc2   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_IXX: begin
        ctrl.alusrc2     = 1'b1;
        ctrl.dmem_to_reg = WB_ALU;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_op      = alu_from_funct3(funct3);
        ctrl.rd          = rd;
        // Only shift immediates carry a funct7; other I-types use those bits as immediate
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (funct7 == F7_ALT && funct3 == 3'b101) ctrl.alu_op = ALU_SRA;
          else if (funct7 != F7_BASE)               illegal     = 1'b1;
        end
      end
      OP_RXX: begin
        ctrl.dmem_to_reg = WB_ALU;
        ctrl.reg_write   = 1'b1;
        ctrl.rd          = rd;
        case (funct7)
          F7_BASE: ctrl.alu_op = alu_from_funct3(funct3);
          F7_ALT: begin
            if (funct3 == 3'b000)      ctrl.alu_op = ALU_SUB;
            else if (funct3 == 3'b101) ctrl.alu_op = ALU_SRA;
            else                       illegal     = 1'b1;
          end
          F7_MULDIV: begin
            if (EN_M) ctrl.alu_op = muldiv_from_funct3(funct3);
            else      illegal     = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal)              ctrl           = '0;
    else if (ctrl.rd == '0)   ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered control decoder: ID/EX output register with valid/ready
// handshake, one-cycle load-use hazard tracker and branch/jump flush.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 6,
  parameter bit          EN_M     = 1'b0,
  parameter int unsigned REG_AW   = 5
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         instr_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                alusrc1_o,
  output logic                alusrc2_o,
  output logic [1:0]          dmem_to_reg_o,
  output logic                reg_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                branch_o,
  output logic                jump_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [REG_AW-1:0]   rd_o,
  output logic                illegal_o
);

  ctrl_bundle_t dec_ctrl;
  ctrl_bundle_t held;
  logic         dec_illegal;
  logic         held_illegal;
  logic         uses_rs1;
  logic         uses_rs2;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic         valid;
  logic         armed;
  logic [4:0]   load_rd;
  logic         hazard;
  logic         ready;
  logic         accept;
  logic         consume;
  logic         arm_next;

  ctrl_decode_comb #(
    .EN_M (EN_M)
  ) u_decode (
    .instr    (instr_i),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .rs1      (rs1),
    .rs2      (rs2)
  );

  // Handshake and load-use hazard detection
  always_comb begin
    hazard   = armed & ((uses_rs1 & (rs1 == load_rd)) | (uses_rs2 & (rs2 == load_rd)));
    ready    = (~valid | out_ready_i) & ~hazard & ~flush_i;
    accept   = in_valid_i & ready;
    consume  = valid & out_ready_i;
    arm_next = consume & held.mem_read & (held.rd != '0);
  end

  // ID/EX register: flush drops the bundle, accept loads, consume empties
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid        <= 1'b0;
      held         <= '0;
      held_illegal <= 1'b0;
    end else if (flush_i) begin
      valid <= 1'b0;
    end else if (accept) begin
      valid        <= 1'b1;
      held         <= dec_ctrl;
      held_illegal <= dec_illegal;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

  // Load tracker: armed for the single cycle after a load leaves for EX
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      armed   <= 1'b0;
      load_rd <= '0;
    end else if (flush_i) begin
      armed   <= 1'b0;
      load_rd <= '0;
    end else begin
      armed <= arm_next;
      if (arm_next) load_rd <= held.rd;
    end
  end

  assign in_ready_o    = ready;
  assign out_valid_o   = valid;
  assign alusrc1_o     = held.alusrc1;
  assign alusrc2_o     = held.alusrc2;
  assign dmem_to_reg_o = held.dmem_to_reg;
  assign reg_write_o   = held.reg_write;
  assign mem_read_o    = held.mem_read;
  assign mem_write_o   = held.mem_write;
  assign branch_o      = held.branch;
  assign jump_o        = held.jump;
  assign alu_op_o      = ALU_OP_W'(held.alu_op);
  assign rd_o          = REG_AW'(held.rd);
  assign illegal_o     = held_illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances (EN_M=0 and EN_M=1) share one
// stimulus stream; a behavioural model predicts both every cycle.
module tb_ctrl_decode_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;

  logic        in_ready  [2];
  logic        out_valid [2];
  logic        alusrc1   [2];
  logic        alusrc2   [2];
  logic [1:0]  wb        [2];
  logic        reg_write [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic        branch    [2];
  logic        jump      [2];
  logic [5:0]  alu_op    [2];
  logic [4:0]  rd        [2];
  logic        illegal   [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.ALU_OP_W(6), .EN_M(1'b0), .REG_AW(5)) dut0 (
    .clk_i(clk), .reset_ni(reset_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready[0]), .instr_i(instr), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready), .alusrc1_o(alusrc1[0]), .alusrc2_o(alusrc2[0]),
    .dmem_to_reg_o(wb[0]), .reg_write_o(reg_write[0]), .mem_read_o(mem_read[0]),
    .mem_write_o(mem_write[0]), .branch_o(branch[0]), .jump_o(jump[0]),
    .alu_op_o(alu_op[0]), .rd_o(rd[0]), .illegal_o(illegal[0]));

  ctrl_decode_pipe #(.ALU_OP_W(6), .EN_M(1'b1), .REG_AW(5)) dut1 (
    .clk_i(clk), .reset_ni(reset_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready[1]), .instr_i(instr), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready), .alusrc1_o(alusrc1[1]), .alusrc2_o(alusrc2[1]),
    .dmem_to_reg_o(wb[1]), .reg_write_o(reg_write[1]), .mem_read_o(mem_read[1]),
    .mem_write_o(mem_write[1]), .branch_o(branch[1]), .jump_o(jump[1]),
    .alu_op_o(alu_op[1]), .rd_o(rd[1]), .illegal_o(illegal[1]));

  typedef struct {
    int a1, a2, wb, rw, mr, mw, br, jp, alu, rd, ill;
  } exp_t;

  // Model state per instance
  bit   m_valid [2];
  exp_t m_cur   [2];
  bit   m_armed [2];
  int   m_ldrd  [2];

  task automatic check(input string name, input int k, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[dut%0d] actual=%0d expected=%0d at %0t", name, k, act, exp, $time);
    end
  endtask

  // Decode from the instruction-set rules
  function automatic exp_t model_decode(input logic [31:0] ins, input bit en_m);
    exp_t e;
    int op, f3, f7, rdi;
    bit bad;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]); rdi = int'(ins[11:7]);
    bad = 0;
    e = '{default: 0};
    if (op == 'h37) begin e.a2 = 1; e.wb = 3; e.rw = 1; e.alu = 15; e.rd = rdi; end
    else if (op == 'h17) begin e.a1 = 1; e.a2 = 1; e.wb = 1; e.rw = 1; e.rd = rdi; end
    else if (op == 'h6F) begin e.a1 = 1; e.a2 = 1; e.wb = 2; e.rw = 1; e.jp = 1; e.rd = rdi; end
    else if (op == 'h67) begin e.a2 = 1; e.wb = 2; e.rw = 1; e.jp = 1; e.rd = rdi; end
    else if (op == 'h63) begin
      e.br = 1;
      if (f3 < 2) e.alu = 9;
      else if (f3 == 4 || f3 == 5) e.alu = 2;
      else if (f3 >= 6) e.alu = 3;
      else bad = 1;
    end
    else if (op == 'h03) begin e.a2 = 1; e.rw = 1; e.mr = 1; e.rd = rdi; end
    else if (op == 'h23) begin e.a2 = 1; e.mw = 1; end
    else if (op == 'h13) begin
      e.a2 = 1; e.wb = 1; e.rw = 1; e.rd = rdi; e.alu = f3;
      if (f3 == 1 && f7 != 0) bad = 1;
      if (f3 == 5) begin
        if (f7 == 32) e.alu = 8;
        else if (f7 != 0) bad = 1;
      end
    end
    else if (op == 'h33) begin
      e.wb = 1; e.rw = 1; e.rd = rdi;
      if (f7 == 0) e.alu = f3;
      else if (f7 == 32 && f3 == 0) e.alu = 9;
      else if (f7 == 32 && f3 == 5) e.alu = 8;
      else if (f7 == 1 && en_m) e.alu = 16 + f3;
      else bad = 1;
    end
    else bad = 1;
    if (bad) begin e = '{default: 0}; e.ill = 1; end
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  function automatic bit reads_rs1(input logic [31:0] ins);
    return !(ins[6:0] == 7'h37 || ins[6:0] == 7'h17 || ins[6:0] == 7'h6F);
  endfunction

  function automatic bit reads_rs2(input logic [31:0] ins);
    return ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63;
  endfunction

  task automatic model_reset(input int k);
    m_valid[k] = 0;
    m_cur[k]   = '{default: 0};
    m_armed[k] = 0;
    m_ldrd[k]  = 0;
  endtask

  // Compare the instance against the model, then step the model over the next edge
  task automatic cmp_adv(input int k);
    bit haz, rdy, cons, acc, arm;
    if (!reset_n) model_reset(k);
    haz = m_armed[k] && ((reads_rs1(instr) && int'(instr[19:15]) == m_ldrd[k]) ||
                         (reads_rs2(instr) && int'(instr[24:20]) == m_ldrd[k]));
    rdy = (!m_valid[k] || out_ready) && !haz && !flush;
    check("out_valid", k, int'(out_valid[k]), int'(m_valid[k]));
    check("in_ready", k, int'(in_ready[k]), int'(rdy));
    if (m_valid[k] || !reset_n) begin
      check("alusrc1", k, int'(alusrc1[k]), m_cur[k].a1);
      check("alusrc2", k, int'(alusrc2[k]), m_cur[k].a2);
      check("dmem_to_reg", k, int'(wb[k]), m_cur[k].wb);
      check("reg_write", k, int'(reg_write[k]), m_cur[k].rw);
      check("mem_read", k, int'(mem_read[k]), m_cur[k].mr);
      check("mem_write", k, int'(mem_write[k]), m_cur[k].mw);
      check("branch", k, int'(branch[k]), m_cur[k].br);
      check("jump", k, int'(jump[k]), m_cur[k].jp);
      check("alu_op", k, int'(alu_op[k]), m_cur[k].alu);
      check("rd", k, int'(rd[k]), m_cur[k].rd);
      check("illegal", k, int'(illegal[k]), m_cur[k].ill);
    end
    if (reset_n) begin
      cons = m_valid[k] && out_ready;
      acc  = in_valid && rdy;
      if (flush) begin
        m_valid[k] = 0;
        m_armed[k] = 0;
        m_ldrd[k]  = 0;
      end else begin
        arm = cons && m_cur[k].mr == 1 && m_cur[k].rd != 0;
        if (arm) m_ldrd[k] = m_cur[k].rd;
        m_armed[k] = arm;
        if (acc) begin
          m_cur[k]   = model_decode(instr, k == 1);
          m_valid[k] = 1;
        end else if (cons) begin
          m_valid[k] = 0;
        end
      end
    end
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(negedge clk);
      cmp_adv(0);
      cmp_adv(1);
    end
  end

  // Reset is asynchronous: the model follows it immediately
  always @(negedge reset_n) begin
    model_reset(0);
    model_reset(1);
  end

  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    instr     = ins;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    logic [4:0] rdf, r1, r2;
    logic [2:0] f3;
    case ($urandom_range(0, 9))
      0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6F; 3: op = 7'h67; 4: op = 7'h63;
      5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13; 8: op = 7'h33;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    rdf = 5'($urandom_range(0, 3));
    r1  = 5'($urandom_range(0, 3));
    r2  = 5'($urandom_range(0, 3));
    f3  = 3'($urandom);
    return {f7, r2, r1, f3, rdf, op};
  endfunction

  localparam logic [31:0] I_ADD3  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LW5   = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] I_ADD65 = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] I_ADD61 = 32'h00208333; // add x6,x1,x2
  localparam logic [31:0] I_SUB7  = 32'h402083B3; // sub x7,x1,x2
  localparam logic [31:0] I_MUL1  = 32'h023100B3; // mul x1,x2,x3

  initial begin
    exp_t e;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;

    // Pin the model with hand-derived decodes
    e = model_decode(I_ADD3, 0);
    check("model_add_alu", 0, e.alu, 0);
    check("model_add_rw", 0, e.rw, 1);
    check("model_add_wb", 0, e.wb, 1);
    check("model_add_rd", 0, e.rd, 3);
    e = model_decode(I_SUB7, 0);
    check("model_sub_alu", 0, e.alu, 9);
    e = model_decode(I_MUL1, 1);
    check("model_mul_alu", 1, e.alu, 16);
    e = model_decode(I_MUL1, 0);
    check("model_mul_ill", 0, e.ill, 1);

    repeat (3) @(posedge clk);
    at_neg();
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", k, int'(out_valid[k]), 0);
      check("rst_illegal", k, int'(illegal[k]), 0);
      check("rst_reg_write", k, int'(reg_write[k]), 0);
      check("rst_alu_op", k, int'(alu_op[k]), 0);
      check("rst_rd", k, int'(rd[k]), 0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;

    // First transaction
    step(1, I_ADD3, 1, 0); at_neg();
    check("add_in_ready", 0, int'(in_ready[0]), 1);
    step(0, '0, 1, 0); at_neg();
    check("add_valid", 0, int'(out_valid[0]), 1);
    check("add_alu", 0, int'(alu_op[0]), 0);
    check("add_rw", 0, int'(reg_write[0]), 1);
    check("add_wb", 0, int'(wb[0]), 1);
    check("add_rd", 0, int'(rd[0]), 3);

    // Load-use: one bubble after the load leaves
    step(1, I_LW5, 1, 0);
    step(0, '0, 1, 0); at_neg();
    check("lw_mem_read", 0, int'(mem_read[0]), 1);
    step(1, I_ADD65, 1, 0); at_neg();
    check("hazard_stall", 0, int'(in_ready[0]), 0);
    step(1, I_ADD65, 1, 0); at_neg();
    check("hazard_release", 0, int'(in_ready[0]), 1);
    step(0, '0, 1, 0); at_neg();
    check("hazard_accept_valid", 0, int'(out_valid[0]), 1);
    check("hazard_accept_rd", 0, int'(rd[0]), 6);

    step(1, I_LW5, 1, 0);
    step(0, '0, 1, 0);
    step(1, I_ADD61, 1, 0); at_neg();
    check("no_stall", 0, int'(in_ready[0]), 1);
    step(0, '0, 1, 0); at_neg();
    check("no_stall_rd", 0, int'(rd[0]), 6);

    // Hold under back-pressure, then consume+accept with no bubble
    step(1, I_SUB7, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, I_ADD3, 0, 0); at_neg();
      check("hold_valid", 0, int'(out_valid[0]), 1);
      check("hold_alu", 0, int'(alu_op[0]), 9);
      check("hold_in_ready", 0, int'(in_ready[0]), 0);
    end
    step(1, I_ADD3, 1, 0); at_neg();
    check("swap_in_ready", 0, int'(in_ready[0]), 1);
    step(0, '0, 1, 0); at_neg();
    check("no_bubble_valid", 0, int'(out_valid[0]), 1);
    check("no_bubble_alu", 0, int'(alu_op[0]), 0);

    // Flush with a held bundle and a valid incoming instruction
    step(1, I_SUB7, 0, 0);
    step(1, I_ADD3, 0, 1); at_neg();
    check("flush_in_ready", 0, int'(in_ready[0]), 0);
    step(0, '0, 0, 0); at_neg();
    check("flush_drop", 0, int'(out_valid[0]), 0);

    // M extension enabled vs disabled
    step(1, I_MUL1, 1, 0);
    step(0, '0, 1, 0); at_neg();
    check("mul_alu", 1, int'(alu_op[1]), 16);
    check("mul_rw", 1, int'(reg_write[1]), 1);
    check("mul_legal", 1, int'(illegal[1]), 0);
    check("mul_illegal", 0, int'(illegal[0]), 1);
    check("mul_no_rw", 0, int'(reg_write[0]), 0);

    // Unknown opcode
    step(1, 32'h0000007F, 1, 0);
    step(0, '0, 1, 0); at_neg();
    check("op7f_illegal", 0, int'(illegal[0]), 1);
    check("op7f_en", 0, int'(reg_write[0]) + int'(mem_read[0]) + int'(mem_write[0]) +
                        int'(branch[0]) + int'(jump[0]), 0);

    // Asynchronous reset while holding
    step(1, I_SUB7, 0, 0);
    step(0, '0, 0, 0); at_neg();
    check("pre_reset_valid", 0, int'(out_valid[0]), 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset", 0, int'(out_valid[0]), 0);
    check("async_reset", 1, int'(out_valid[1]), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset_n   = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      instr     = rand_instr();
    end

    step(0, '0, 1, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
